calc_exec_sequencer: RTL and testbench
======================================

Name: calc_exec_sequencer

Overview:
- Sequences one calculator operation per completed entry from the input buffer.
- On a `finish` pulse it captures SRC/DST/ALU_OP and substitutes the running answer for any operand equal to IC_ANS.
- It then drives the shared multi-cycle ALU through a start/done handshake, updates the answer register, and appends the result to a small history ring read by the display scanner.
- Sits between the input buffer and the ALU/display.

Parameters:
- IC_N, from input-interface constants, command/opcode width.
- HIST_DEPTH, 8, history ring entries (power of two, ≥2).
- HIST_AW, 3, log2(HIST_DEPTH).

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low
- finish  in  1  one-cycle entry-complete strobe; SRC/DST/ALU_OP valid in the same cycle
- SRC  in  16  first operand value or IC_ANS
- DST  in  16  second operand value or IC_ANS
- ALU_OP  in  IC_N  IC_OPAD/OPSB/OPAN/OPOR/OPLS
- alu_start  out  1  one-cycle start pulse
- alu_a  out  16  operand A, held stable from start until done
- alu_b  out  16  operand B, held stable from start until done
- alu_op  out  IC_N  opcode, held stable from start until done
- alu_done  in  1  one-cycle completion strobe, result valid with it
- alu_result  in  16  ALU result
- ans  out  16  current answer
- busy  out  1  operation in flight or pending
- done  out  1  one-cycle pulse after ans update
- overrun  out  1  sticky: an entry was dropped
- clr_ovr  in  1  clears overrun
- hist_rd_idx  in  HIST_AW  0 = newest, k = k-th older
- hist_rd_data  out  16  registered read data, 1-cycle latency
- hist_count  out  HIST_AW+1  valid entries, saturates at HIST_DEPTH

Behaviour:
- Reset values:
  - All outputs 0; alu_op = IC_OPAN.
  - State IDLE; pending slot empty; history write pointer 0.
  - Reset mid-operation aborts; a late alu_done after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, COMMIT.
- IDLE:
  - On finish, or pending slot full, move to ISSUE.
  - A live finish has priority over the pending slot only when the slot is empty.
- ISSUE:
  - Operand resolution: any operand == IC_ANS is replaced by the ans value current at this cycle. A queued command therefore sees the preceding result.
  - Load alu_a/alu_b/alu_op and assert alu_start for exactly 1 cycle; move to WAIT.
- WAIT:
  - Hold operands until alu_done; then latch alu_result and move to COMMIT.
  - alu_done outside WAIT is ignored.
- COMMIT:
  - ans <= result; write result at history write pointer; pointer increments mod HIST_DEPTH.
  - hist_count increments, saturating at HIST_DEPTH.
  - Assert done for 1 cycle.
  - If pending slot full, go to ISSUE; else go to IDLE.
- Minimum latency: finish to done = 3 cycles plus ALU latency, measured from the finish edge to the done cycle.
- Pending slot (depth 1):
  - finish while state ≠ IDLE captures SRC/DST/ALU_OP into the slot if it is empty.
  - If the slot is full, the entry is dropped and overrun is set.
  - The slot is consumed in the cycle ISSUE loads from it.
- Captured fields are raw; IC_ANS resolution always happens in ISSUE.
- busy = (state ≠ IDLE) | slot full.
- overrun: set-dominant over a simultaneous clr_ovr.
- History:
  - Read address = (wr_ptr − 1 − hist_rd_idx) mod HIST_DEPTH; data registered.
  - Indices ≥ hist_count return 0.
  - A read coincident with a COMMIT write returns the pre-write mapping.
- Arithmetic: all values 16-bit unsigned. Wrap-around of results is the ALU's concern; no saturation is applied here.

Decomposition:
- Shared constants, in the existing input-interface constant set: IC_ANS and the opcode encodings (IC_OPAD, IC_OPSB, IC_OPAN, IC_OPOR, IC_OPLS).
- Local to this block: FSM state localparams.
- One sub-module: calc_hist_ring (RAM array, write pointer, count, registered indexed read).

Test Plan:
- Reset, then finish with SRC=12, DST=30, ADD; ALU done 2 cycles after start → alu_a=12, alu_b=30; ans=42; done pulses once; hist_count=1; hist idx0 reads 42.
- After the above, finish with SRC=IC_ANS, DST=2, SUB → alu_a=42, alu_b=2; ans=40; idx1 reads 42.
- Back-to-back: second finish while in WAIT, with SRC=IC_ANS → queued, issued right after COMMIT with alu_a equal to the first result; busy stays high throughout.
- Third finish while the slot is full → dropped; overrun=1. clr_ovr clears it. clr_ovr together with a new overrun event → stays 1.
- Nine commits with HIST_DEPTH=8 → hist_count=8; idx0 = 9th result; idx7 = 2nd result.
- Reset asserted during WAIT, then stray alu_done → ans stays 0; no done pulse; state IDLE.

Source files
------------

// File: rtl/calc_exec_sequencer_pkg.sv
// Input-interface constants shared by the calculator datapath: opcode width,
// opcode encodings and the "use running answer" operand marker.
package calc_exec_sequencer_pkg;

  localparam int IC_N = 3;

  localparam logic [15:0] IC_ANS = 16'hFFFF;

  localparam logic [IC_N-1:0] IC_OPAD = 3'd0;
  localparam logic [IC_N-1:0] IC_OPSB = 3'd1;
  localparam logic [IC_N-1:0] IC_OPAN = 3'd2;
  localparam logic [IC_N-1:0] IC_OPOR = 3'd3;
  localparam logic [IC_N-1:0] IC_OPLS = 3'd4;

  function automatic logic [15:0] resolve_operand(input logic [15:0] v,
                                                  input logic [15:0] ans_v);
    return (v == IC_ANS) ? ans_v : v;
  endfunction

endpackage

// File: rtl/calc_hist_ring.sv
// Result history ring: newest-relative indexed read with one cycle of latency,
// saturating entry count; unwritten indices read as zero.
module calc_hist_ring #(
  parameter int HIST_DEPTH = 8,
  parameter int HIST_AW    = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               wr_en,
  input  logic [15:0]        wr_data,
  input  logic [HIST_AW-1:0] rd_idx,
  output logic [15:0]        rd_data,
  output logic [HIST_AW:0]   count
);

  logic [15:0]        mem [HIST_DEPTH];
  logic [HIST_AW-1:0] wr_ptr;
  logic [HIST_AW-1:0] rd_addr;

  // Modulo arithmetic relies on HIST_DEPTH being a power of two.
  assign rd_addr = wr_ptr - HIST_AW'(1) - rd_idx;

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= ({1'b0, rd_idx} < count) ? mem[rd_addr] : '0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + HIST_AW'(1);
        if (count != (HIST_AW+1)'(HIST_DEPTH)) count <= count + (HIST_AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/calc_exec_sequencer.sv
// Issues one ALU operation per completed entry, resolves IC_ANS operands against
// the running answer, keeps a one-deep pending slot and logs results to history.
module calc_exec_sequencer
  import calc_exec_sequencer_pkg::*;
#(
  parameter int HIST_DEPTH = 8,
  parameter int HIST_AW    = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               finish,
  input  logic [15:0]        SRC,
  input  logic [15:0]        DST,
  input  logic [IC_N-1:0]    ALU_OP,
  output logic               alu_start,
  output logic [15:0]        alu_a,
  output logic [15:0]        alu_b,
  output logic [IC_N-1:0]    alu_op,
  input  logic               alu_done,
  input  logic [15:0]        alu_result,
  output logic [15:0]        ans,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  input  logic               clr_ovr,
  input  logic [HIST_AW-1:0] hist_rd_idx,
  output logic [15:0]        hist_rd_data,
  output logic [HIST_AW:0]   hist_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_COMMIT} state_t;

  state_t          state;
  logic [15:0]     cur_src, cur_dst, slot_src, slot_dst, result_q;
  logic [IC_N-1:0] cur_op, slot_op;
  logic            slot_full, from_slot;
  logic            accept_live, capture, drop;

  // A live finish in IDLE goes straight to ISSUE via cur_*; otherwise it parks
  // in the slot, and from_slot tells ISSUE which source to load.
  assign accept_live = finish && (state == ST_IDLE) && !slot_full;
  assign capture     = finish && !accept_live && !slot_full;
  assign drop        = finish && slot_full;
  assign busy        = (state != ST_IDLE) || slot_full;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      cur_op    <= IC_OPAN;
      slot_src  <= '0;
      slot_dst  <= '0;
      slot_op   <= IC_OPAN;
      slot_full <= 1'b0;
      from_slot <= 1'b0;
      result_q  <= '0;
      alu_start <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= IC_OPAN;
      ans       <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      done      <= 1'b0;

      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;

      if (capture) begin
        slot_full <= 1'b1;
        slot_src  <= SRC;
        slot_dst  <= DST;
        slot_op   <= ALU_OP;
      end else if (state == ST_ISSUE && from_slot) begin
        slot_full <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept_live) begin
            cur_src   <= SRC;
            cur_dst   <= DST;
            cur_op    <= ALU_OP;
            from_slot <= 1'b0;
            state     <= ST_ISSUE;
          end else if (slot_full) begin
            from_slot <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_a     <= resolve_operand(from_slot ? slot_src : cur_src, ans);
          alu_b     <= resolve_operand(from_slot ? slot_dst : cur_dst, ans);
          alu_op    <= from_slot ? slot_op : cur_op;
          alu_start <= 1'b1;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_done) begin
            result_q <= alu_result;
            state    <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          ans  <= result_q;
          done <= 1'b1;
          if (slot_full) begin
            from_slot <= 1'b1;
            state     <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  calc_hist_ring #(
    .HIST_DEPTH (HIST_DEPTH),
    .HIST_AW    (HIST_AW)
  ) u_hist (
    .Clock   (Clock),
    .Reset   (Reset),
    .wr_en   (state == ST_COMMIT),
    .wr_data (result_q),
    .rd_idx  (hist_rd_idx),
    .rd_data (hist_rd_data),
    .count   (hist_count)
  );

endmodule

// File: tb/tb_calc_exec_sequencer.sv
// Directed bench for calc_exec_sequencer: the bench plays the ALU and checks
// operands, answers, pulses, overrun and history against hand-computed values.
module tb_calc_exec_sequencer;
  import calc_exec_sequencer_pkg::*;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic            finish = 1'b0;
  logic [15:0]     SRC = '0, DST = '0;
  logic [IC_N-1:0] ALU_OP = IC_OPAD;
  logic            alu_start;
  logic [15:0]     alu_a, alu_b;
  logic [IC_N-1:0] alu_op;
  logic            alu_done = 1'b0;
  logic [15:0]     alu_result = '0;
  logic [15:0]     ans;
  logic            busy, done, overrun;
  logic            clr_ovr = 1'b0;
  logic [2:0]      hist_rd_idx = '0;
  logic [15:0]     hist_rd_data;
  logic [3:0]      hist_count;

  int checks = 0;
  int failures = 0;

  calc_exec_sequencer #(.HIST_DEPTH(8), .HIST_AW(3)) dut (
    .Clock(Clock), .Reset(Reset), .finish(finish), .SRC(SRC), .DST(DST),
    .ALU_OP(ALU_OP), .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_done(alu_done), .alu_result(alu_result), .ans(ans),
    .busy(busy), .done(done), .overrun(overrun), .clr_ovr(clr_ovr),
    .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data), .hist_count(hist_count)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20 && alu_start !== 1'b1; i++) step();
    chk({tag, "_start"}, 32'(alu_start), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && done !== 1'b1; i++) step();
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_alu(input logic [15:0] res);
    alu_done = 1'b1;
    alu_result = res;
    step();
    alu_done = 1'b0;
  endtask

  task automatic give_finish(input logic [15:0] s, input logic [15:0] d, input logic [IC_N-1:0] op);
    SRC = s; DST = d; ALU_OP = op; finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  // One isolated operation with ALU latency of two cycles after start.
  task automatic single_op(input string tag, input logic [15:0] s, input logic [15:0] d,
                           input logic [IC_N-1:0] op, input logic [15:0] ea,
                           input logic [15:0] eb, input logic [15:0] res,
                           input logic [3:0] ecount);
    give_finish(s, d, op);
    wait_start(tag);
    chk({tag, "_a"}, 32'(alu_a), 32'(ea));
    chk({tag, "_b"}, 32'(alu_b), 32'(eb));
    chk({tag, "_op"}, 32'(alu_op), 32'(op));
    step();
    pulse_alu(res);
    wait_done(tag);
    chk({tag, "_ans"}, 32'(ans), 32'(res));
    chk({tag, "_count"}, 32'(hist_count), 32'(ecount));
    step();
    chk({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  task automatic hist_read(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    hist_rd_idx = idx;
    step();
    chk(tag, 32'(hist_rd_data), 32'(exp));
  endtask

  initial begin
    repeat (2) step();
    chk("rst_ans", 32'(ans), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_start", 32'(alu_start), 32'd0);
    chk("rst_aluop", 32'(alu_op), 32'(IC_OPAN));
    chk("rst_count", 32'(hist_count), 32'd0);
    Reset = 1'b1;
    step();

    single_op("add", 16'd12, 16'd30, IC_OPAD, 16'd12, 16'd30, 16'd42, 4'd1);
    hist_read("h_add_idx0", 3'd0, 16'd42);

    single_op("sub_ans", IC_ANS, 16'd2, IC_OPSB, 16'd42, 16'd2, 16'd40, 4'd2);
    hist_read("h2_idx0", 3'd0, 16'd40);
    hist_read("h2_idx1", 3'd1, 16'd42);
    hist_read("h2_idx2_empty", 3'd2, 16'd0);

    // Back-to-back: A in flight, B queued with IC_ANS, C dropped.
    give_finish(16'd5, 16'd7, IC_OPAD);
    wait_start("bbA");
    chk("bbA_a", 32'(alu_a), 32'd5);
    chk("bbA_b", 32'(alu_b), 32'd7);
    step();
    give_finish(IC_ANS, 16'd1, IC_OPOR);
    chk("bb_busy_q", 32'(busy), 32'd1);
    chk("bb_ovr_pre", 32'(overrun), 32'd0);
    give_finish(16'd100, 16'd100, IC_OPAN);
    chk("bb_ovr_set", 32'(overrun), 32'd1);
    pulse_alu(16'd12);
    step();
    chk("bbA_done", 32'(done), 32'd1);
    chk("bbA_ans", 32'(ans), 32'd12);
    chk("bb_busy_commit", 32'(busy), 32'd1);
    step();
    chk("bbB_start", 32'(alu_start), 32'd1);
    chk("bbB_a", 32'(alu_a), 32'd12);
    chk("bbB_b", 32'(alu_b), 32'd1);
    chk("bbB_op", 32'(alu_op), 32'(IC_OPOR));
    chk("bbB_busy", 32'(busy), 32'd1);
    step();
    pulse_alu(16'd13);
    wait_done("bbB");
    chk("bbB_ans", 32'(ans), 32'd13);
    chk("bbB_count", 32'(hist_count), 32'd4);
    chk("bb_idle_busy", 32'(busy), 32'd0);
    step();

    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Second burst: drop coincides with clr_ovr, set must win.
    give_finish(16'h00F0, 16'h003C, IC_OPAN);
    wait_start("bbD");
    chk("bbD_a", 32'(alu_a), 32'h00F0);
    step();
    give_finish(IC_ANS, 16'd3, IC_OPLS);
    clr_ovr = 1'b1;
    give_finish(16'd1, 16'd1, IC_OPAD);
    clr_ovr = 1'b0;
    chk("ovr_set_dom", 32'(overrun), 32'd1);
    pulse_alu(16'h0030);
    wait_done("bbD");
    chk("bbD_ans", 32'(ans), 32'h0030);
    wait_start("bbE");
    chk("bbE_a", 32'(alu_a), 32'h0030);
    chk("bbE_b", 32'(alu_b), 32'd3);
    step();
    pulse_alu(16'h0180);
    wait_done("bbE");
    chk("bbE_ans", 32'(ans), 32'h0180);
    step();

    single_op("op7", 16'd100, 16'd1, IC_OPAD, 16'd100, 16'd1, 16'd101, 4'd7);
    single_op("op8", 16'd200, 16'd2, IC_OPAD, 16'd200, 16'd2, 16'd202, 4'd8);
    single_op("op9", 16'd300, 16'd3, IC_OPAD, 16'd300, 16'd3, 16'd303, 4'd8);
    hist_read("h9_idx0", 3'd0, 16'd303);
    hist_read("h9_idx3", 3'd3, 16'h0180);
    hist_read("h9_idx7", 3'd7, 16'd40);

    // Reset during WAIT, then a stray alu_done.
    give_finish(16'd5, 16'd5, IC_OPAD);
    wait_start("rw");
    step();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    pulse_alu(16'd10);
    for (int i = 0; i < 5; i++) begin
      chk("rw_done", 32'(done), 32'd0);
      step();
    end
    chk("rw_ans", 32'(ans), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_start", 32'(alu_start), 32'd0);
    chk("rw_count", 32'(hist_count), 32'd0);
    chk("rw_ovr", 32'(overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
